// File: rtl/counter_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker_pkg
// Description : Shared types and default constants for the counter checker:
//               FSM state encoding, default widths/thresholds and small
//               arithmetic helpers used by the checker datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_checker_pkg;

  // Default configuration of the checker
  localparam int C_DEFAULT_WIDTH       = 22;
  localparam int C_DEFAULT_LOCK_THRESH = 4;
  localparam int C_DEFAULT_TIMEOUT     = 64;
  localparam int C_ERR_W               = 8;

  // State encodings, kept as plain constants so legacy code can compare
  // against raw bit patterns if needed
  localparam logic [1:0] C_ST_SEARCH = 2'd0;
  localparam logic [1:0] C_ST_VERIFY = 2'd1;
  localparam logic [1:0] C_ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    ST_SEARCH = C_ST_SEARCH,
    ST_VERIFY = C_ST_VERIFY,
    ST_LOCKED = C_ST_LOCKED
  } cc_state_e;

  // Increment the error counter, holding at all-ones
  function automatic logic [C_ERR_W-1:0] sat_inc_err(input logic [C_ERR_W-1:0] i_val);
    return (i_val == {C_ERR_W{1'b1}}) ? i_val : i_val + C_ERR_W'(1);
  endfunction

endpackage : counter_checker_pkg
`default_nettype wire

// File: rtl/sync_stable.sv
`default_nettype none
// ============================================================================
// Module      : sync_stable
// Description : Brings the externally clocked counter word into the clk
//               domain through two flops (s1, s2), keeps the previous s2 in
//               s3 and flags when the synchronized word has settled and when
//               a settled word differs from a reference value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_stable
  import counter_checker_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_ref,
  output logic [WIDTH-1:0] o_value,
  output logic             o_stable,
  output logic             o_changed
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;
  // One bit per pipeline stage that has captured a real post-reset sample;
  // s3 must hold such a sample before s2 == s3 means anything, otherwise the
  // cleared flops would look like a settled zero.
  logic [2:0]       r_fill;

  // Synchronizer chain plus history register and fill tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_fill <= '0;
    end else begin
      r_s1   <= i_data;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  // A multi-bit word crossing domains may be captured mid-transition with
  // bits skewed; requiring two consecutive identical captures filters that.
  assign o_value   = r_s2;
  assign o_stable  = r_fill[2] && (r_s2 == r_s3);
  assign o_changed = o_stable && (r_s2 != i_ref);

endmodule : sync_stable
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker
// Description : Monitors a free-running external counter. Settled values are
//               accepted into last_value; consecutive +1 steps establish lock,
//               violations while locked are counted, and an idle timer flags
//               a stalled source.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH       = C_DEFAULT_WIDTH,
  parameter int LOCK_THRESH = C_DEFAULT_LOCK_THRESH,
  parameter int TIMEOUT     = C_DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  output logic               locked,
  output logic               stall,
  output logic [C_ERR_W-1:0] err_count,
  output logic [WIDTH-1:0]   last_value
);

  localparam int C_TMR_W = $clog2(TIMEOUT + 1);
  localparam int C_RUN_W = $clog2(LOCK_THRESH + 1);

  cc_state_e          r_state;
  logic [WIDTH-1:0]   r_last;
  logic               r_have;
  logic [C_RUN_W-1:0] r_good_run;
  logic [C_TMR_W-1:0] r_timer;
  logic [C_ERR_W-1:0] r_err;
  logic               r_locked;
  logic               r_stall;

  logic [WIDTH-1:0]   w_value;
  logic               w_stable;
  logic               w_changed;
  logic               w_accept;
  logic               w_good;
  logic               w_expire;
  logic [C_RUN_W-1:0] w_run_inc;

  sync_stable #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_data    (data_in),
    .i_ref     (r_last),
    .o_value   (w_value),
    .o_stable  (w_stable),
    .o_changed (w_changed)
  );

  // Until the first value after reset has been taken, last_value merely holds
  // its cleared reset value, so any settled word is accepted (including zero).
  // Afterwards a word must differ from last_value; this also keeps a frozen
  // source from being re-accepted immediately after a stall.
  assign w_accept  = w_changed || (w_stable && !r_have);

  // Wraps naturally at WIDTH bits, so all-ones followed by zero is good
  assign w_good    = (w_value == (r_last + WIDTH'(1)));
  assign w_run_inc = r_good_run + C_RUN_W'(1);

  // Expiry is the edge on which the idle timer would reach TIMEOUT; an
  // accept on the same edge takes priority.
  assign w_expire  = !w_accept && (r_timer == C_TMR_W'(TIMEOUT - 1));

  // Idle timer: cycles since the last accept, saturating at TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_accept) begin
      r_timer <= '0;
    end else if (r_timer != C_TMR_W'(TIMEOUT)) begin
      r_timer <= r_timer + C_TMR_W'(1);
    end
  end

  // Saturating count of increment violations observed while locked
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_accept && (r_state == ST_LOCKED) && !w_good) begin
      r_err <= sat_inc_err(r_err);
    end
  end

  // Lock FSM with last_value, good-run count, locked and stall flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SEARCH;
      r_last     <= '0;
      r_have     <= 1'b0;
      r_good_run <= '0;
      r_locked   <= 1'b0;
      r_stall    <= 1'b0;
    end else if (w_accept) begin
      r_last  <= w_value;
      r_have  <= 1'b1;
      r_stall <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          r_state    <= ST_VERIFY;
          r_good_run <= '0;
          r_locked   <= 1'b0;
        end
        ST_VERIFY: begin
          if (w_good) begin
            r_good_run <= w_run_inc;
            if (w_run_inc == C_RUN_W'(LOCK_THRESH)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end else begin
            r_good_run <= '0;
          end
        end
        ST_LOCKED: begin
          if (!w_good) begin
            r_state    <= ST_VERIFY;
            r_good_run <= '0;
            r_locked   <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_SEARCH;
          r_good_run <= '0;
          r_locked   <= 1'b0;
        end
      endcase
    end else if (w_expire && (r_state != ST_SEARCH)) begin
      // Source has gone quiet: drop back to searching and flag the stall
      // until the next accepted value
      r_state    <= ST_SEARCH;
      r_good_run <= '0;
      r_locked   <= 1'b0;
      r_stall    <= 1'b1;
    end
  end

  assign locked     = r_locked;
  assign stall      = r_stall;
  assign err_count  = r_err;
  assign last_value = r_last;

endmodule : counter_checker
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_checker
// Description : Self-checking bench for counter_checker. Stimulus is a list
//               of source segments (value, hold time); a segment-level model
//               predicts each change of the output tuple and queues it, and
//               a monitor compares every observed output change in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_checker;
  import counter_checker_pkg::*;

  localparam int W   = C_DEFAULT_WIDTH;
  localparam int LT  = C_DEFAULT_LOCK_THRESH;
  localparam int TO  = C_DEFAULT_TIMEOUT;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         locked;
  logic         stall;
  logic [7:0]   err_count;
  logic [W-1:0] last_value;

  counter_checker #(
    .WIDTH       (W),
    .LOCK_THRESH (LT),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .locked     (locked),
    .stall      (stall),
    .err_count  (err_count),
    .last_value (last_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] last;
    logic         lck;
    logic         stl;
    logic [7:0]   err;
  } snap_t;

  snap_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  snap_t mon_prev = '0;

  // Behavioural model state (per accepted segment, not per clock)
  int    m_last, m_run, m_err, cur_src;
  bit    m_search, m_locked, m_stall;
  snap_t m_prev;

  task automatic m_reset();
    m_last = 0; m_run = 0; m_err = 0;
    m_search = 1'b1; m_locked = 1'b0; m_stall = 1'b0;
    m_prev = '0;
  endtask

  task automatic m_push();
    snap_t s;
    s.last = W'(m_last);
    s.lck  = m_locked;
    s.stl  = m_stall;
    s.err  = 8'(m_err);
    if (s != m_prev) begin
      exp_q.push_back(s);
      m_prev = s;
    end
  endtask

  // A value held for h sample edges is accepted 3 edges after it first
  // arrives; the next value is accepted h edges after that, so the idle
  // limit is crossed exactly when h exceeds TO.
  task automatic m_apply(input int v, input int h);
    if (m_search) begin
      m_search = 1'b0; m_run = 0; m_locked = 1'b0;
    end else if (v == (m_last + 1) % MOD) begin
      if (!m_locked) begin
        m_run = m_run + 1;
        if (m_run == LT) m_locked = 1'b1;
      end
    end else begin
      if (m_locked) begin
        if (m_err < 255) m_err = m_err + 1;
        m_locked = 1'b0;
      end
      m_run = 0;
    end
    m_last  = v;
    m_stall = 1'b0;
    m_push();
    if (h > TO) begin
      m_search = 1'b1; m_locked = 1'b0; m_stall = 1'b1; m_run = 0;
      m_push();
    end
  endtask

  task automatic chk(input string name, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
    end
  endtask

  // Drive one segment starting at a negedge; optional one-cycle glitch
  task automatic seg(input int v, input int h, input bit glitch = 1'b0);
    data_in = W'(v);
    cur_src = v;
    m_apply(v, h);
    if (glitch) begin
      repeat (4) @(negedge clk);
      data_in = W'((v + 5 + int'($urandom_range(0, 100))) % MOD);
      @(negedge clk);
      data_in = W'(v);
      repeat (h - 5) @(negedge clk);
    end else begin
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic good(input int h, input bit glitch = 1'b0);
    seg((cur_src + 1) % MOD, h, glitch);
  endtask

  task automatic bad(input int h);
    seg((cur_src + 2 + int'($urandom_range(0, 1000))) % MOD, h);
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic pulse_reset_and_check(input string tag);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_last_value"}, last_value, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_err_count"}, err_count, 0);
    m_reset();
    exp_q.delete();
    mon_prev = '0;
    mon_en = 1'b1;
  endtask

  // Monitor: every change of the output tuple must match the next prediction
  initial begin
    snap_t c, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        c = {last_value, locked, stall, err_count};
        if (c != mon_prev) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: got last=%h locked=%b stall=%b err=%0d, required no change",
                     c.last, c.lck, c.stl, c.err);
          end else begin
            e = exp_q.pop_front();
            if (c !== e) begin
              n_bad++;
              $display("FAIL output_event: got last=%h locked=%b stall=%b err=%0d required last=%h locked=%b stall=%b err=%0d",
                       c.last, c.lck, c.stl, c.err, e.last, e.lck, e.stl, e.err);
            end
          end
          mon_prev = c;
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #(10_000_000);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    cur_src = 0;
    rst = 1'b1;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_last_value", last_value, 0);
    chk("reset_locked", locked, 0);
    chk("reset_stall", stall, 0);
    chk("reset_err_count", err_count, 0);
    rst = 1'b0;
    mon_prev = '0;
    mon_en = 1'b1;

    // Counting source 0,1,2,... every 7 cycles: lock on value 4
    for (int i = 0; i < 10; i++) begin
      seg(i, 7);
      if (i == 3) chk("not_locked_at_3", locked, 0);
      if (i == 4) chk("locked_at_4", locked, 1);
    end
    chk("count_err_zero", err_count, 0);

    // Frozen source: stall, then relock after the next change
    seg(10, 100);
    chk("frozen_stall", stall, 1);
    chk("frozen_unlocked", locked, 0);
    seg(11, 7);
    chk("stall_cleared", stall, 0);
    for (int i = 0; i < 4; i++) good(7);
    chk("relocked_after_stall", locked, 1);

    // Jump 0x10 -> 0x20 while locked
    seg(16, 7);
    seg(32, 7);
    chk("jump_err", err_count, 1);
    chk("jump_unlocked", locked, 0);
    for (int i = 0; i < 4; i++) good(7);
    chk("jump_relocked", locked, 1);

    // Idle boundary: a hold of exactly TO is not a stall, TO+1 is
    good(TO);
    good(7);
    good(TO + 1);
    good(7);
    for (int i = 0; i < 4; i++) good(5);

    // Single-cycle glitches between stable values
    for (int i = 0; i < 4; i++) good(10, 1'b1);
    drain("drain_phase1");

    // Wrap through all-ones to zero while locked, from a clean reset
    pulse_reset_and_check("rst_wrap");
    seg(32'h3FFFF8, 6);
    for (int i = 0; i < 9; i++) good(6);
    chk("wrap_locked", locked, 1);
    chk("wrap_last", last_value, 32'h000001);
    chk("wrap_err", err_count, 0);

    // Randomised mix of good steps, bad jumps, glitches and long holds
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 3) bad(int'($urandom_range(3, 12)));
      else if (r < 6) good(int'($urandom_range(6, 12)), 1'b1);
      else if (r == 6) good(int'($urandom_range(TO - 2, TO + 20)));
      else good(int'($urandom_range(2, 12)));
    end
    drain("drain_random");

    // Saturate the error counter by repeated relock / violation
    for (int i = 0; i < 4; i++) good(3);
    for (int i = 0; i < 260; i++) begin
      bad(3);
      for (int k = 0; k < 4; k++) good(3);
    end
    chk("err_saturated", err_count, 255);
    drain("drain_sat");

    // One-cycle reset clears everything; first value lands at edge 4
    pulse_reset_and_check("rst_final");
    data_in = W'(5);
    cur_src = 5;
    m_apply(5, 10);
    repeat (3) @(negedge clk);
    chk("first_accept_not_before_edge4", last_value, 0);
    @(negedge clk);
    chk("first_accept_at_edge4", last_value, 5);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) good(7);
    chk("final_locked", locked, 1);
    drain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_counter_checker
`default_nettype wire
